serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//  Parallel-to-serial transmitter, MSB first, one bit per accepted bit_tick.
//  Accepts a word over a valid/ready handshake, shifts it onto serial_out.
//  Pulses bit_valid for each bit so the far-end receiver can sample on its enable.
//  Pulses done at frame end. Sits between the data source and the serial link.
// PARAMETERS
//  DATA_W   8   word width in bits (>=2)
// PORTS
//  clk        in   1       rising-edge clock, the only clock
//  rst        in   1       synchronous, active-high reset
//  data_in    in   DATA_W  word to send, sampled on handshake
//  data_valid in   1       source has a word on data_in
//  data_ready out  1       block can accept a word (IDLE state)
//  bit_tick   in   1       pacing strobe: one bit leaves per tick
//  serial_out out  1       serial data, registered
//  bit_valid  out  1       1-cycle strobe: serial_out holds a new bit
//  busy       out  1       frame in progress (state != IDLE)
//  done       out  1       1-cycle pulse after last bit of frame
// BEHAVIOUR
//  Interface: one clock clk; rst is synchronous, active-high.
//  Reset: state=IDLE, serial_out=0, bit_valid=0, done=0, busy=0, data_ready=1 on
//   the first cycle after rst deasserts. rst mid-frame aborts the frame; the word is discarded.
//  FSM: IDLE -> SHIFT -> LAST -> IDLE.
//   IDLE: data_ready=1. data_valid&&data_ready at edge: shift_reg<=data_in,
//    cnt<=0, go SHIFT. bit_tick is ignored in IDLE.
//   SHIFT: data_ready=0, busy=1. On bit_tick: serial_out<=shift_reg[DATA_W-1],
//    bit_valid<=1, shift_reg<=shift_reg<<1, cnt<=cnt+1. When the tick sends
//    bit NBITS-1, go LAST. No tick: bit_valid<=0, serial_out holds.
//   LAST: done<=1 for exactly one cycle, bit_valid<=0, go IDLE.
//  NBITS = DATA_W (or DATA_W+1 with parity). cnt width = $clog2(NBITS+1).
//  Latency: tick at edge E -> bit visible with bit_valid=1 from edge E+1 for one cycle.
//   done is asserted 1 cycle after the last bit_valid.
//  bit_tick every cycle: frame = 1 accept + NBITS + 1 done cycle; next accept is
//   possible in the cycle after done (no back-to-back overlap).
//  data_in changes while busy: ignored. data_valid held while busy: no effect until IDLE.
//  bit_tick in the handshake cycle: not consumed. The first bit waits for the next tick.
//  serial_out holds the last bit after frame end until the next frame's first bit.
// CONFIGURATION
//  SERIALIZER_PARITY_EN defined: after DATA_W data bits, one extra bit is sent on
//   the next bit_tick: even parity (^word captured at handshake), with bit_valid.
//   NBITS=DATA_W+1.
//  Undefined: no parity bit, NBITS=DATA_W, no parity register.
// STRUCTURE
//  serializer_pkg: state typedef enum {IDLE,SHIFT,LAST}; localparam NBITS is
//   derived from DATA_W and the macro in the module.
//  Single module, FSM + shift/count datapath. No sub-module is warranted.
// TESTING
//  1 rst, then 0xA5 sent with bit_tick=1 every cycle -> bit_valid on 8 consecutive
//    cycles, serial_out 1,0,1,0,0,1,0,1; done is 1 cycle later; data_ready returns to 1.
//  2 0x3C sent with bit_tick every 3rd cycle -> bits 0,0,1,1,1,1,0,0, each
//    bit_valid 1 cycle after its tick; serial_out stable between ticks.
//  3 rst asserted after 4 bits of 0xFF -> next cycle busy=0, bit_valid=0,
//    data_ready=1; a following 0x01 sends 0,0,0,0,0,0,0,1 with no residue.
//  4 data_valid held high with 0x11 then 0x22 -> 0x11 sent fully; 0x22 accepted only
//    after done, and its first bit follows 0x11's done by >=2 cycles.
//  5 PARITY_EN: 0x07 -> 9 bit_valid strobes, 9th bit=1; 0x03 -> 9th bit=0.
//  6 bit_tick coincident with handshake -> no bit_valid on the next cycle;
//    the first bit appears only after the next bit_tick.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types for the parallel-to-serial transmitter.
// The frame FSM walks IDLE -> SHIFT -> LAST -> IDLE.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LAST  = 2'd2
  } state_e;

endpackage

// File: rtl/serializer.sv
// MSB-first serializer: one bit per bit_tick, done pulse at frame end.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              bit_tick,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              serial_q, serial_d;
  logic              bv_q, bv_d;
  logic              done_q, done_d;
  logic              fill;

`ifdef SERIALIZER_PARITY_EN
  logic par_q, par_d;
  // Parity is shifted in from the bottom, so it reaches the MSB last.
  assign fill = par_q;
`else
  assign fill = 1'b0;
`endif

  // Next-state and datapath: capture in IDLE, shift on tick, pulse done.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    bv_d     = 1'b0;
    done_d   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          shift_d = data_in;
          cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
          par_d   = ^data_in;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          serial_d = shift_q[DATA_W-1];
          bv_d     = 1'b1;
          shift_d  = {shift_q[DATA_W-2:0], fill};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = LAST;
        end
      end
      LAST: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      bv_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      bv_q     <= bv_d;
      done_q   <= done_d;
`ifdef SERIALIZER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_q;
  assign bit_valid  = bv_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: driver queues expected bits,
// monitor pops on bit_valid; a frame-level model predicts strobes.
module tb_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         bit_tick;
  logic         serial_out;
  logic         bit_valid;
  logic         busy;
  logic         done;

  serializer #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .bit_tick   (bit_tick),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  int tick_mode = 0;
  int tcnt = 0;
  bit mon_en = 0;
  int bits_seen = 0;

  // Frame-level expectation: 0 idle, 1 bits owed, 2 frame finished.
  int m_phase = 0;
  int m_left = 0;
  bit exp_bv = 0;
  bit exp_done = 0;
  bit last_bit = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick pacing: every cycle, every 3rd cycle, or random.
  initial begin
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      case (tick_mode)
        0: bit_tick = 1'b1;
        1: bit_tick = (tcnt % 3 == 0);
        default: bit_tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model, evaluated from the inputs seen at each edge.
  always @(posedge clk) begin
    exp_bv = 0;
    exp_done = 0;
    if (rst) begin
      m_phase = 0;
      last_bit = 0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (data_valid) begin
        m_phase = 1;
        m_left = NB;
      end
    end else if (m_phase == 1) begin
      if (bit_tick) begin
        exp_bv = 1;
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else begin
      exp_done = 1;
      m_phase = 0;
    end
  end

  // Monitor: compare strobes and pop expected bits when a bit appears.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("bit_valid", bit_valid, exp_bv);
        chk("done", done, exp_done);
        chk("data_ready", data_ready, 32'(m_phase == 0));
        chk("busy", busy, 32'(m_phase != 0));
        if (bit_valid === 1'b1) begin
          bits_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: got %0b expected none", serial_out);
          end else begin
            last_bit = exp_q.pop_front();
          end
        end
        chk("serial_out", serial_out, last_bit);
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SERIALIZER_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (data_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    wait_ready();
    data_in = w;
    data_valid = 1'b1;
    push_word(w);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((m_phase != 0 || exp_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d bits pending expected 0",
               exp_q.size());
    end
  endtask

  task automatic wait_bits(input int k);
    int n = 0;
    int target = bits_seen + k;
    while (bits_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL bit_timeout: got %0d expected %0d", bits_seen, target);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_data_ready", data_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_serial_out", serial_out, 0);
    mon_en = 1;

    // Ticks every cycle; tick in the handshake cycle is not consumed.
    tick_mode = 0;
    send(8'hA5);
    wait_idle();

    // Sparse ticks, serial_out holds between them.
    tick_mode = 1;
    send(8'h3C);
    wait_idle();

    // Abort mid-frame, then a clean frame.
    tick_mode = 0;
    send(8'hFF);
    wait_bits(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_bit_valid", bit_valid, 0);
    chk("abort_data_ready", data_ready, 1);
    send(8'h01);
    wait_idle();

    // data_valid held across a whole frame.
    wait_ready();
    data_in = 8'h11;
    data_valid = 1'b1;
    push_word(8'h11);
    @(posedge clk);
    #1;
    data_in = 8'h22;
    wait_ready();
    push_word(8'h22);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    wait_idle();

    // Parity-sensitive words.
    send(8'h07);
    wait_idle();
    send(8'h03);
    wait_idle();

    // Random words, random pacing, random gaps.
    tick_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
